whack_sfx: RTL and testbench

Sound-effect generator for the whack-a-mole game, sitting between the game logic and `Audio_Controller`. It turns single-cycle hit/miss event pulses into a timed square-wave tone, mixes it onto the microphone pass-through stream, and drives the controller's read/write handshake. It also exports the active tone code `hit_miss_sound` for display/debug.

---
 rtl/whack_sfx_if.sv | 32 +++
 rtl/whack_sfx.sv | 88 ++++++++
 tb/tb_whack_sfx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/whack_sfx_if.sv
// Event, audio-controller handshake and sample bus for whack_sfx.
// The slave side is the effect generator; the master side is game logic plus Audio_Controller.
interface whack_sfx_if;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        audio_in_available;
    logic        audio_out_allowed;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        read_audio_in;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [1:0]  hit_miss_sound;
    logic        busy;

    modport master (
        output hit_pulse, miss_pulse, audio_in_available, audio_out_allowed,
        output left_channel_audio_in, right_channel_audio_in,
        input  read_audio_in, write_audio_out,
        input  left_channel_audio_out, right_channel_audio_out,
        input  hit_miss_sound, busy
    );

    modport slave (
        input  hit_pulse, miss_pulse, audio_in_available, audio_out_allowed,
        input  left_channel_audio_in, right_channel_audio_in,
        output read_audio_in, write_audio_out,
        output left_channel_audio_out, right_channel_audio_out,
        output hit_miss_sound, busy
    );
endinterface

// File: rtl/whack_sfx.sv
// Hit/miss square-wave tone generator mixed onto the microphone pass-through stream.
// Triggers (hit over miss) restart the tone; it plays for DURATION cycles then returns to idle.
module whack_sfx #(
    parameter int unsigned HIT_HALF  = 68536,
    parameter int unsigned MISS_HALF = 35768,
    parameter int unsigned DURATION  = 12500000,
    parameter logic [31:0] AMPLITUDE = 32'd10000000
) (
    input logic        CLOCK_50,
    input logic        reset,
    whack_sfx_if.slave bus
);

    localparam int unsigned MaxHalf = (HIT_HALF > MISS_HALF) ? HIT_HALF : MISS_HALF;
    localparam int unsigned DurW    = $clog2(DURATION + 1);
    localparam int unsigned HalfW   = $clog2(MaxHalf + 1);

    // Encoding doubles as the exported tone code.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMiss = 2'b01,
        StHit  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DurW-1:0]   dur_q, dur_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic              snd_q, snd_d;
    logic [HalfW-1:0]  half_last;
    logic [31:0]       sound;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            dur_q   <= '0;
            half_q  <= '0;
            snd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            snd_q   <= snd_d;
        end
    end

    assign half_last = (state_q == StHit) ? HalfW'(HIT_HALF - 1) : HalfW'(MISS_HALF - 1);

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        half_d  = half_q;
        snd_d   = snd_q;
        if (bus.hit_pulse || bus.miss_pulse) begin
            state_d = bus.hit_pulse ? StHit : StMiss;
            dur_d   = DurW'(DURATION - 1);
            half_d  = '0;
            snd_d   = 1'b1;
        end else if (state_q == StIdle || dur_q == '0) begin
            state_d = StIdle;
            dur_d   = '0;
            half_d  = '0;
            snd_d   = 1'b0;
        end else begin
            dur_d = dur_q - 1'b1;
            if (half_q == half_last) begin
                half_d = '0;
                snd_d  = ~snd_q;
            end else begin
                half_d = half_q + 1'b1;
            end
        end
    end

    always_comb begin
        sound = 32'd0;
        if (state_q != StIdle) begin
            sound = snd_q ? AMPLITUDE : (32'd0 - AMPLITUDE);
        end
    end

    assign bus.left_channel_audio_out  = bus.left_channel_audio_in + sound;
    assign bus.right_channel_audio_out = bus.right_channel_audio_in + sound;
    assign bus.read_audio_in           = bus.audio_in_available & bus.audio_out_allowed;
    assign bus.write_audio_out         = bus.audio_in_available & bus.audio_out_allowed;
    assign bus.hit_miss_sound          = state_q;
    assign bus.busy                    = (state_q != StIdle);

endmodule

// File: tb/tb_whack_sfx.sv
// Self-checking bench for whack_sfx: directed scenarios plus random traffic against a
// tone model expressed as elapsed-cycles-since-trigger arithmetic.
module tb_whack_sfx;
    localparam int unsigned HitHalf  = 4;
    localparam int unsigned MissHalf = 3;
    localparam int unsigned Dur      = 20;
    localparam logic [31:0] Amp      = 32'd100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    whack_sfx_if bus ();

    whack_sfx #(
        .HIT_HALF (HitHalf),
        .MISS_HALF(MissHalf),
        .DURATION (Dur),
        .AMPLITUDE(Amp)
    ) u_dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    int busy_cnt;
    logic [31:0] seen_left[$];

    // Reference: a tone is just (active, kind, cycles since the trigger edge).
    bit m_active = 1'b0;
    bit m_hit    = 1'b0;
    int m_k      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sound();
        int half;
        if (!m_active) return 32'd0;
        half = m_hit ? HitHalf : MissHalf;
        return ((m_k / half) % 2 == 0) ? Amp : (32'd0 - Amp);
    endfunction

    task automatic tick(input bit r, input bit h, input bit m, input bit av, input bit al,
                        input logic [31:0] l, input logic [31:0] rr);
        logic [1:0] code;
        @(negedge clk);
        rst                        = r;
        bus.hit_pulse              = h;
        bus.miss_pulse             = m;
        bus.audio_in_available     = av;
        bus.audio_out_allowed      = al;
        bus.left_channel_audio_in  = l;
        bus.right_channel_audio_in = rr;
        #1;
        code = !m_active ? 2'b00 : (m_hit ? 2'b10 : 2'b01);
        check_val("read", 32'(bus.read_audio_in), 32'(av & al));
        check_val("write", 32'(bus.write_audio_out), 32'(av & al));
        check_val("busy", 32'(bus.busy), 32'(m_active));
        check_val("code", 32'(bus.hit_miss_sound), 32'(code));
        check_val("left", bus.left_channel_audio_out, l + model_sound());
        check_val("right", bus.right_channel_audio_out, rr + model_sound());
        if (bus.busy) busy_cnt++;
        seen_left.push_back(bus.left_channel_audio_out);
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
        end else if (h || m) begin
            m_active = 1'b1;
            m_hit    = h;
            m_k      = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k >= Dur) m_active = 1'b0;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, 1, 32'd0, 32'd0);
    endtask

    initial begin
        bus.hit_pulse              = 1'b0;
        bus.miss_pulse             = 1'b0;
        bus.audio_in_available     = 1'b0;
        bus.audio_out_allowed      = 1'b0;
        bus.left_channel_audio_in  = 32'd0;
        bus.right_channel_audio_in = 32'd0;

        // Reset beats a simultaneous hit.
        tick(1, 1, 0, 1, 1, 32'h12345678, 32'h0);
        tick(1, 1, 0, 1, 1, 32'h12345678, 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_pass", bus.left_channel_audio_out, 32'h12345678);

        // Single hit: exactly Dur busy cycles, +/- Amp alternating every HitHalf.
        tick(0, 1, 0, 1, 1, 32'd0, 32'd0);
        busy_cnt = 0;
        seen_left.delete();
        idle_ticks(25);
        check_val("hit_len", 32'(busy_cnt), 32'd20);
        check_val("hit_ph0", seen_left[0], 32'd100);
        check_val("hit_ph4", seen_left[4], 32'hFFFFFF9C);
        check_val("hit_ph8", seen_left[8], 32'd100);
        check_val("hit_end", seen_left[20], 32'd0);

        // Both pulses: hit wins; a miss 5 cycles later takes over for a full tone.
        tick(0, 1, 1, 1, 1, 32'd0, 32'd0);
        check_val("both_code", 32'(bus.hit_miss_sound), 32'd0);
        idle_ticks(4);
        tick(0, 0, 1, 1, 1, 32'd0, 32'd0);
        check_val("pre_miss", 32'(bus.hit_miss_sound), 32'd2);
        busy_cnt = 0;
        seen_left.delete();
        idle_ticks(25);
        check_val("miss_len", 32'(busy_cnt), 32'd20);
        check_val("miss_ph0", seen_left[0], 32'd100);

        // Retrigger at cycle 15 extends busy to 35 cycles total.
        busy_cnt = 0;
        tick(0, 1, 0, 1, 1, 32'd0, 32'd0);
        idle_ticks(14);
        tick(0, 1, 0, 1, 1, 32'd0, 32'd0);
        seen_left.delete();
        idle_ticks(25);
        check_val("retrig_len", 32'(busy_cnt), 32'd35);
        check_val("retrig_ph", seen_left[0], 32'd100);

        // Wrap-around mix and handshake combinations during a tone.
        tick(0, 1, 0, 0, 0, 32'd0, 32'd0);
        tick(0, 0, 0, 1, 0, 32'hFFFFFFF0, 32'd0);
        check_val("wrap_pos", bus.left_channel_audio_out, 32'h00000054);
        check_val("hs_10", 32'(bus.read_audio_in), 32'd0);
        idle_ticks(3);
        tick(0, 0, 0, 0, 1, 32'd0, 32'd0);
        check_val("wrap_neg", bus.right_channel_audio_out, 32'hFFFFFF9C);
        check_val("hs_01", 32'(bus.write_audio_out), 32'd0);
        idle_ticks(20);
        tick(0, 0, 0, 0, 0, 32'd0, 32'd0);
        check_val("hs_idle_00", 32'(bus.read_audio_in), 32'd0);

        // Mid-tone reset on a miss, then a later full tone.
        tick(0, 0, 1, 1, 1, 32'd0, 32'd0);
        idle_ticks(6);
        tick(1, 0, 0, 1, 1, 32'd0, 32'd0);
        tick(0, 0, 0, 1, 1, 32'd0, 32'd0);
        check_val("mid_rst", 32'(bus.busy), 32'd0);
        tick(0, 0, 1, 1, 1, 32'd0, 32'd0);
        busy_cnt = 0;
        idle_ticks(25);
        check_val("post_rst_len", 32'(busy_cnt), 32'd20);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(99) == 0), ($urandom_range(29) == 0),
                 ($urandom_range(29) == 0), 1'($urandom), 1'($urandom), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
